ristretto_prefetch_queue: RTL and testbench

Parametrised, multi-outstanding successor to the single-request prefetch buffer between the fetch unit (FU) and the IF stage. Owns the fetch PC, issues up to MaxOutstanding pipelined requests, stores in-order responses with their PC and error flag in a Depth-entry circular queue, and delivers them over a valid/ready handshake. A redirect flushes the queue and discards responses still in flight, so no NOP injection or reject flag is needed downstream.

---
 rtl/ristretto_prefetch_queue_if.sv | 29 ++
 rtl/ristretto_prefetch_queue.sv | 152 +++++++++++++++
 tb/tb_ristretto_prefetch_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ristretto_prefetch_queue_if.sv
// rtl/ristretto_prefetch_queue_if.sv - fetch-unit and IF-stage handshake bundle
interface ristretto_prefetch_queue_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) ();
  logic                 fu_req_o;
  logic [AddrWidth-1:0] fu_addr_o;
  logic                 fu_gnt_i;
  logic                 fu_rvalid_i;
  logic [DataWidth-1:0] fu_rdata_i;
  logic                 fu_err_i;
  logic                 if_valid_o;
  logic                 if_ready_i;
  logic [DataWidth-1:0] if_instr_o;
  logic [AddrWidth-1:0] if_pc_o;
  logic                 if_err_o;

  // Prefetch queue side: drives requests toward the FU and entries toward IF.
  modport master (
    output fu_req_o, fu_addr_o, if_valid_o, if_instr_o, if_pc_o, if_err_o,
    input  fu_gnt_i, fu_rvalid_i, fu_rdata_i, fu_err_i, if_ready_i
  );

  // Environment side: the FU and the IF stage.
  modport slave (
    input  fu_req_o, fu_addr_o, if_valid_o, if_instr_o, if_pc_o, if_err_o,
    output fu_gnt_i, fu_rvalid_i, fu_rdata_i, fu_err_i, if_ready_i
  );
endinterface

// File: rtl/ristretto_prefetch_queue.sv
// rtl/ristretto_prefetch_queue.sv - multi-outstanding instruction prefetch queue
module ristretto_prefetch_queue #(
  parameter int                   DataWidth      = 32,
  parameter int                   AddrWidth      = 32,
  parameter int                   Depth          = 8,
  parameter int                   MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] BootAddr       = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [AddrWidth-1:0]   flush_pc_i,
  ristretto_prefetch_queue_if.master bus,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam int SW = CW + 1;
  localparam logic [OW-1:0]        MaxOut = OW'(MaxOutstanding);
  localparam logic [SW-1:0]        DepthS = SW'(Depth);
  localparam logic [CW-1:0]        DepthC = CW'(Depth);
  localparam logic [AddrWidth-1:0] PcStep = AddrWidth'(4);

  logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddrWidth-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;
  logic [OW-1:0]        discard_q, discard_d;
  logic                 halt_q, halt_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [DataWidth-1:0] data_q [Depth];
  logic [DataWidth-1:0] data_d [Depth];
  logic [AddrWidth-1:0] pc_q [Depth];
  logic [AddrWidth-1:0] pc_d [Depth];
  logic [Depth-1:0]     err_q, err_d;

  logic          empty;
  logic [SW-1:0] reserved;
  logic          issue;
  logic          grant;
  logic          keep;
  logic          pop;

  // Handshake decode: space is reserved at issue so a kept response always fits.
  always_comb begin
    empty    = (count_q == '0);
    reserved = SW'(count_q) + SW'(outstanding_q);
    issue    = ~rst_i & ~flush_i & ~halt_q & (outstanding_q < MaxOut) & (reserved < DepthS);
    grant    = issue & bus.fu_gnt_i;
    keep     = bus.fu_rvalid_i & (discard_q == '0) & ~flush_i;
    pop      = ~rst_i & ~empty & ~flush_i & bus.if_ready_i;
  end

  // Next-state: flush overrides push, pop and grant; stale responses are counted off.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    halt_d        = halt_q;
    data_d        = data_q;
    pc_d          = pc_q;
    err_d         = err_q;
    if (flush_i) begin
      count_d       = '0;
      head_d        = tail_q;
      halt_d        = 1'b0;
      fetch_pc_d    = flush_pc_i;
      resp_pc_d     = flush_pc_i;
      outstanding_d = outstanding_q - OW'(bus.fu_rvalid_i);
      discard_d     = outstanding_q - OW'(bus.fu_rvalid_i);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PcStep;
      end
      outstanding_d = outstanding_q + OW'(grant) - OW'(bus.fu_rvalid_i);
      if (bus.fu_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end
      if (keep) begin
        data_d[head_q] = bus.fu_rdata_i;
        pc_d[head_q]   = resp_pc_q;
        err_d[head_q]  = bus.fu_err_i;
        head_d         = head_q + PW'(1);
        resp_pc_d      = resp_pc_q + PcStep;
        if (bus.fu_err_i) begin
          halt_d = 1'b1;
        end
      end
      if (pop) begin
        tail_d = tail_q + PW'(1);
      end
      count_d = count_q + CW'(keep) - CW'(pop);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DepthC);
  end

  // State registers with synchronous reset; entries cleared so reset outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= BootAddr;
      resp_pc_q     <= BootAddr;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      halt_q        <= 1'b0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      err_q         <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halt_q        <= halt_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      err_q         <= err_d;
      data_q        <= data_d;
      pc_q          <= pc_d;
    end
  end

  assign bus.fu_req_o   = issue;
  assign bus.fu_addr_o  = rst_i ? BootAddr : fetch_pc_q;
  assign bus.if_valid_o = ~rst_i & ~empty & ~flush_i;
  assign bus.if_instr_o = rst_i ? '0 : data_q[tail_q];
  assign bus.if_pc_o    = rst_i ? '0 : pc_q[tail_q];
  assign bus.if_err_o   = rst_i ? 1'b0 : err_q[tail_q];
  assign occupancy_o    = count_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
endmodule

// File: tb/tb_ristretto_prefetch_queue.sv
// tb/tb_ristretto_prefetch_queue.sv - randomized self-checking bench for the prefetch queue
module tb_ristretto_prefetch_queue;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 8;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BOOT  = 32'h100;
  localparam logic [31:0] NOERR = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  occ;
  logic        empty;
  logic        full;

  always #5 clk = ~clk;

  ristretto_prefetch_queue_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

  ristretto_prefetch_queue #(
    .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH), .MaxOutstanding(MAXO), .BootAddr(BOOT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flush_pc),
    .bus(bus), .occupancy_o(occ), .empty_o(empty), .full_o(full)
  );

  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } ent_t;

  req_t        pend[$];
  ent_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n, epoch, last_due, lat;
  logic [31:0] m_pc, err_addr;
  bit          m_halt;
  int          n_grant, n_pop, first_valid, max_occ;
  bit          have_gnt, have_pop;
  logic [31:0] first_gnt_addr, first_pop_pc, last_pop_pc, err_pop_pc;

  function automatic logic [31:0] fu_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_grant = 0; n_pop = 0; first_valid = -1; have_gnt = 0; have_pop = 0;
    first_gnt_addr = 0; first_pop_pc = 0; last_pop_pc = 0; err_pop_pc = 0;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; flush_pc = 0;
    bus.fu_gnt_i = 0; bus.fu_rvalid_i = 0; bus.fu_rdata_i = 0; bus.fu_err_i = 0; bus.if_ready_i = 0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_fu_req", 32'(bus.fu_req_o), 0);
    chk("rst_fu_addr", bus.fu_addr_o, BOOT);
    chk("rst_if_valid", 32'(bus.if_valid_o), 0);
    chk("rst_if_instr", bus.if_instr_o, 0);
    chk("rst_if_pc", bus.if_pc_o, 0);
    chk("rst_if_err", 32'(bus.if_err_o), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    pend.delete(); expq.delete();
    m_halt = 0; m_pc = BOOT; epoch++; last_due = 0; cyc_n = 1; max_occ = 0;
    clear_stats();
    rst = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the reference, advance the reference.
  task automatic cyc(input bit fl, input logic [31:0] fpc, input bit rdy, input bit gnt);
    bit   rv, e_req, e_valid, g, p;
    req_t r;
    ent_t e;
    rv = (pend.size() > 0) && (pend[0].due <= cyc_n);
    flush = fl; flush_pc = fpc;
    bus.if_ready_i  = rdy;
    bus.fu_gnt_i    = gnt;
    bus.fu_rvalid_i = rv;
    bus.fu_rdata_i  = rv ? fu_data(pend[0].addr) : $urandom;
    bus.fu_err_i    = rv ? (pend[0].addr == err_addr) : 1'($urandom);
    #1;
    e_req   = !fl && !m_halt && (pend.size() < MAXO) && (expq.size() + pend.size() < DEPTH);
    e_valid = !fl && (expq.size() > 0);
    chk("fu_req", 32'(bus.fu_req_o), 32'(e_req));
    if (e_req) chk("fu_addr", bus.fu_addr_o, m_pc);
    chk("if_valid", 32'(bus.if_valid_o), 32'(e_valid));
    if (expq.size() > 0) begin
      chk("if_pc", bus.if_pc_o, expq[0].pc);
      chk("if_instr", bus.if_instr_o, expq[0].data);
      chk("if_err", 32'(bus.if_err_o), 32'(expq[0].err));
    end
    chk("occupancy", 32'(occ), 32'(expq.size()));
    chk("empty", 32'(empty), 32'(expq.size() == 0));
    chk("full", 32'(full), 32'(expq.size() == DEPTH));
    if (32'(occ) > 32'(max_occ)) max_occ = int'(occ);
    g = e_req && gnt;
    p = e_valid && rdy;
    if (e_valid && first_valid < 0) first_valid = cyc_n;
    if (p) begin
      e = expq.pop_front();
      if (!have_pop) begin first_pop_pc = e.pc; have_pop = 1; end
      last_pop_pc = e.pc;
      if (e.err) err_pop_pc = e.pc;
      n_pop++;
    end
    if (rv) begin
      r = pend.pop_front();
      if (!fl && r.epoch == epoch) begin
        e.pc = r.addr; e.data = fu_data(r.addr); e.err = (r.addr == err_addr);
        expq.push_back(e);
        if (e.err) m_halt = 1;
      end
    end
    if (fl) begin
      expq.delete(); m_halt = 0; epoch++; m_pc = fpc;
    end
    if (g) begin
      r.addr  = m_pc;
      r.due   = (cyc_n + lat > last_due + 1) ? cyc_n + lat : last_due + 1;
      r.epoch = epoch;
      last_due = r.due;
      pend.push_back(r);
      if (!have_gnt) begin first_gnt_addr = m_pc; have_gnt = 1; end
      m_pc += 32'd4;
      n_grant++;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    int guard;
    epoch = 0; lat = 1; err_addr = NOERR;

    // Stream at full rate with 1-cycle FU latency.
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1);
    chk("stream_first_valid", 32'(first_valid), 3);
    chk("stream_pops", 32'(n_pop), 18);
    chk("stream_last_pc", last_pop_pc, 32'h144);

    // Fill under backpressure, then drain and refetch.
    do_reset();
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1);
    chk("fill_grants", 32'(n_grant), 8);
    #1;
    chk("fill_full", 32'(full), 1);
    chk("fill_req", 32'(bus.fu_req_o), 0);
    chk("fill_occ", 32'(occ), 8);
    clear_stats();
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1);
    chk("drain_first_pc", first_pop_pc, BOOT);
    chk("refetch_addr", first_gnt_addr, 32'h120);

    // Flush with two requests in flight.
    do_reset();
    lat = 3;
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(1, 32'h400, 1, 1);
    #1;
    chk("flush_occ", 32'(occ), 0);
    clear_stats();
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 1);
    chk("flush_first_pc", first_pop_pc, 32'h400);

    // Flush coinciding with a response and a grant attempt.
    lat = 2;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);
    guard = 0;
    while (!((pend.size() > 0) && (pend[0].due <= cyc_n)) && guard < 20) begin
      cyc(0, 0, 1, 1);
      guard++;
    end
    chk("resp_due_bound", 32'(guard < 20), 1);
    cyc(1, 32'h600, 1, 1);
    clear_stats();
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1);
    chk("coinc_first_gnt", first_gnt_addr, 32'h600);
    chk("coinc_first_pc", first_pop_pc, 32'h600);

    // Error on the third response halts fetching until a flush.
    do_reset();
    lat = 1; err_addr = 32'h108;
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1);
    chk("err_grants", 32'(n_grant), 4);
    chk("err_pc", err_pop_pc, 32'h108);
    #1;
    chk("err_halt_req", 32'(bus.fu_req_o), 0);
    cyc(1, 32'h200, 1, 1);
    clear_stats();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1);
    chk("err_resume", first_gnt_addr, 32'h200);
    err_addr = NOERR;

    // Random backpressure, stalls, latencies and occasional flushes across pointer wrap.
    do_reset();
    guard = 0;
    while (n_pop < 3 * DEPTH + 8 && guard < 3000) begin
      lat = $urandom_range(1, 4);
      cyc(($urandom % 40) == 0, {16'h0, 14'($urandom), 2'b00}, 1'($urandom), ($urandom % 10) < 7);
      guard++;
    end
    chk("wrap_pops", 32'(n_pop >= 3 * DEPTH + 8), 1);
    chk("wrap_max_occ", 32'(max_occ <= DEPTH), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
